// File: rtl/rv32i_types.sv
// Shared types for the CPU memory path: arbiter state and request record.
package rv32i_types;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  rmask;
      logic [3:0]  wmask;
      logic [31:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the cpu imem/dmem ports, the arbiter and the shared memory port.
interface mem_port_arbiter_if;
   logic [31:0] imem_addr;
   logic [3:0]  imem_rmask;
   logic [31:0] imem_rdata;
   logic        imem_resp;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_rmask;
   logic [3:0]  dmem_wmask;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_resp;
   logic [31:0] mem_addr;
   logic [3:0]  mem_rmask;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_resp;

   // Arbiter view.
   modport slave (
      input  imem_addr, imem_rmask, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
      input  mem_rdata, mem_resp,
      output imem_rdata, imem_resp, dmem_rdata, dmem_resp,
      output mem_addr, mem_rmask, mem_wmask, mem_wdata
   );

   // Environment view (requesters plus memory model).
   modport master (
      output imem_addr, imem_rmask, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
      output mem_rdata, mem_resp,
      input  imem_rdata, imem_resp, dmem_rdata, dmem_resp,
      input  mem_addr, mem_rmask, mem_wmask, mem_wdata
   );
endinterface

// File: rtl/mem_req_slot.sv
// One-entry pending request slot. A new request is accepted when the slot
// is empty or is retiring in the same cycle; otherwise it is dropped.
module mem_req_slot
   import rv32i_types::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     i_capture,
   input  logic     i_retire,
   input  mem_req_t i_req,
   output logic     o_valid,
   output mem_req_t o_req
);

   logic     r_valid;
   mem_req_t r_req;
   logic     w_load;

   assign w_load  = i_capture & (~r_valid | i_retire);
   assign o_valid = r_valid;
   assign o_req   = r_req;

   // Capture has precedence over retire so a request arriving in the
   // response cycle refills the slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_req   <= '0;
      end else if (w_load) begin
         r_valid <= 1'b1;
         r_req   <= i_req;
      end else if (i_retire) begin
         r_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (imem) and load/store (dmem).
// dmem wins ties; one transaction in flight; responses routed by owner.
module mem_port_arbiter
   import rv32i_types::*;
(
   input  logic              clk,
   input  logic              rst,
   mem_port_arbiter_if.slave bus
);

   arb_state_t r_state, w_next;
   mem_req_t   w_i_in, w_d_in, w_i_slot, w_d_slot, w_i_eff, w_d_eff, w_grant;
   logic       w_i_req, w_d_req, w_i_vld, w_d_vld, w_i_ret, w_d_ret;
   logic       w_i_eff_vld, w_d_eff_vld, w_decide, w_issue;

   logic [31:0] r_mem_addr, r_mem_wdata;
   logic [3:0]  r_mem_rmask, r_mem_wmask;

   assign w_i_req = |bus.imem_rmask;
   assign w_d_req = |(bus.dmem_rmask | bus.dmem_wmask);
   assign w_i_in  = '{addr: bus.imem_addr, rmask: bus.imem_rmask, wmask: 4'h0, wdata: 32'h0};
   assign w_d_in  = '{addr: bus.dmem_addr, rmask: bus.dmem_rmask,
                      wmask: bus.dmem_wmask, wdata: bus.dmem_wdata};

   // The in-flight request stays in its slot until its response retires it.
   assign w_i_ret = bus.mem_resp & (r_state == BUSY_I);
   assign w_d_ret = bus.mem_resp & (r_state == BUSY_D);

   mem_req_slot u_islot (
      .clk(clk), .rst(rst), .i_capture(w_i_req), .i_retire(w_i_ret),
      .i_req(w_i_in), .o_valid(w_i_vld), .o_req(w_i_slot)
   );

   mem_req_slot u_dslot (
      .clk(clk), .rst(rst), .i_capture(w_d_req), .i_retire(w_d_ret),
      .i_req(w_d_in), .o_valid(w_d_vld), .o_req(w_d_slot)
   );

   // What each side would hold after this edge: a surviving slot entry,
   // else the request arriving now (which the slot is about to capture).
   assign w_i_eff_vld = (w_i_vld & ~w_i_ret) | w_i_req;
   assign w_d_eff_vld = (w_d_vld & ~w_d_ret) | w_d_req;
   assign w_i_eff     = (w_i_vld & ~w_i_ret) ? w_i_slot : w_i_in;
   assign w_d_eff     = (w_d_vld & ~w_d_ret) ? w_d_slot : w_d_in;

   // A grant is decided when idle or when the current transaction completes.
   assign w_decide = (r_state == IDLE) | bus.mem_resp;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Next state and grant selection; dmem has priority.
   always_comb begin
      w_next  = r_state;
      w_grant = w_d_eff;
      w_issue = 1'b0;
      if (w_decide) begin
         if (w_d_eff_vld) begin
            w_next  = BUSY_D;
            w_grant = w_d_eff;
            w_issue = 1'b1;
         end else if (w_i_eff_vld) begin
            w_next  = BUSY_I;
            w_grant = w_i_eff;
            w_issue = 1'b1;
         end else begin
            w_next  = IDLE;
         end
      end
   end

   // Shared-port registers: masks pulse for one cycle per issue, addr/wdata hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mem_addr  <= 32'h0;
         r_mem_wdata <= 32'h0;
         r_mem_rmask <= 4'h0;
         r_mem_wmask <= 4'h0;
      end else begin
         r_mem_rmask <= 4'h0;
         r_mem_wmask <= 4'h0;
         if (w_issue) begin
            r_mem_addr  <= w_grant.addr;
            r_mem_wdata <= w_grant.wdata;
            r_mem_rmask <= w_grant.rmask;
            r_mem_wmask <= w_grant.wmask;
         end
      end
   end

   assign bus.mem_addr   = r_mem_addr;
   assign bus.mem_wdata  = r_mem_wdata;
   assign bus.mem_rmask  = r_mem_rmask;
   assign bus.mem_wmask  = r_mem_wmask;

   assign bus.imem_resp  = w_i_ret;
   assign bus.dmem_resp  = w_d_ret;
   assign bus.imem_rdata = bus.mem_rdata;
   assign bus.dmem_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;
   import rv32i_types::*;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_err;

   mem_port_arbiter_if bus ();

   mem_port_arbiter dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s act=%h exp=%h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      bus.imem_addr  = 32'h0;
      bus.imem_rmask = 4'h0;
      bus.dmem_addr  = 32'h0;
      bus.dmem_rmask = 4'h0;
      bus.dmem_wmask = 4'h0;
      bus.dmem_wdata = 32'h0;
      bus.mem_rdata  = 32'h0;
      bus.mem_resp   = 1'b0;
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      quiet();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("rst_state", 32'(dut.r_state), 32'(IDLE));
      chk("rst_addr",  bus.mem_addr, 32'h0);
      chk("rst_wdata", bus.mem_wdata, 32'h0);
      chk("rst_rmask", 32'(bus.mem_rmask), 32'h0);
      chk("rst_wmask", 32'(bus.mem_wmask), 32'h0);
      chk("rst_iresp", 32'(bus.imem_resp), 32'h0);
      chk("rst_dresp", 32'(bus.dmem_resp), 32'h0);
      tick();

      // Single fetch.
      bus.imem_addr = 32'h1eceb000; bus.imem_rmask = 4'hf; #1;
      chk("f1_c1_rmask", 32'(bus.mem_rmask), 32'h0);
      tick();
      quiet(); #1;
      chk("f1_c2_rmask", 32'(bus.mem_rmask), 32'hf);
      chk("f1_c2_addr",  bus.mem_addr, 32'h1eceb000);
      chk("f1_c2_wmask", 32'(bus.mem_wmask), 32'h0);
      tick();
      #1;
      chk("f1_c3_rmask", 32'(bus.mem_rmask), 32'h0);
      chk("f1_c3_addr",  bus.mem_addr, 32'h1eceb000);
      chk("f1_c3_iresp", 32'(bus.imem_resp), 32'h0);
      tick();
      bus.mem_resp = 1'b1; bus.mem_rdata = 32'h00000013; #1;
      chk("f1_c4_iresp", 32'(bus.imem_resp), 32'h1);
      chk("f1_c4_idata", bus.imem_rdata, 32'h00000013);
      chk("f1_c4_dresp", 32'(bus.dmem_resp), 32'h0);
      tick();
      quiet(); #1;
      chk("f1_c5_iresp", 32'(bus.imem_resp), 32'h0);
      chk("f1_c5_state", 32'(dut.r_state), 32'(IDLE));
      chk("f1_c5_rmask", 32'(bus.mem_rmask), 32'h0);
      tick();

      // Simultaneous requests: store first, fetch right after, then back-to-back fetch.
      bus.imem_addr = 32'h1eceb004; bus.imem_rmask = 4'hf;
      bus.dmem_addr = 32'h1eceb100; bus.dmem_wmask = 4'h3; bus.dmem_wdata = 32'h0000dead;
      tick();
      quiet(); #1;
      chk("sim_st_wmask", 32'(bus.mem_wmask), 32'h3);
      chk("sim_st_rmask", 32'(bus.mem_rmask), 32'h0);
      chk("sim_st_addr",  bus.mem_addr, 32'h1eceb100);
      chk("sim_st_wdata", bus.mem_wdata, 32'h0000dead);
      chk("sim_st_state", 32'(dut.r_state), 32'(BUSY_D));
      tick();
      bus.mem_resp = 1'b1; #1;
      chk("sim_dresp", 32'(bus.dmem_resp), 32'h1);
      chk("sim_iresp0", 32'(bus.imem_resp), 32'h0);
      chk("sim_wmask0", 32'(bus.mem_wmask), 32'h0);
      tick();
      bus.mem_resp = 1'b0; #1;
      chk("sim_ld_rmask", 32'(bus.mem_rmask), 32'hf);
      chk("sim_ld_wmask", 32'(bus.mem_wmask), 32'h0);
      chk("sim_ld_addr",  bus.mem_addr, 32'h1eceb004);
      chk("sim_ld_wdata", bus.mem_wdata, 32'h0);
      chk("sim_ld_state", 32'(dut.r_state), 32'(BUSY_I));
      tick();
      bus.mem_resp = 1'b1; bus.mem_rdata = 32'h00100093;
      bus.imem_addr = 32'h1eceb008; bus.imem_rmask = 4'hf; #1;
      chk("b2b_iresp", 32'(bus.imem_resp), 32'h1);
      chk("b2b_idata", bus.imem_rdata, 32'h00100093);
      chk("b2b_dresp", 32'(bus.dmem_resp), 32'h0);
      tick();
      quiet(); #1;
      chk("b2b_rmask", 32'(bus.mem_rmask), 32'hf);
      chk("b2b_addr",  bus.mem_addr, 32'h1eceb008);
      chk("b2b_state", 32'(dut.r_state), 32'(BUSY_I));
      tick();
      bus.mem_resp = 1'b1; bus.mem_rdata = 32'h00200113; #1;
      chk("b2b_iresp2", 32'(bus.imem_resp), 32'h1);
      chk("b2b_idata2", bus.imem_rdata, 32'h00200113);
      tick();
      quiet(); #1;
      chk("b2b_idle",  32'(dut.r_state), 32'(IDLE));
      chk("b2b_rmask0", 32'(bus.mem_rmask), 32'h0);
      tick();

      // Occupied slot: second load while the first is outstanding is dropped.
      bus.dmem_addr = 32'h00002000; bus.dmem_rmask = 4'hf;
      tick();
      bus.dmem_addr = 32'h00003000; bus.dmem_rmask = 4'h1; #1;
      chk("occ_rmask", 32'(bus.mem_rmask), 32'hf);
      chk("occ_addr",  bus.mem_addr, 32'h00002000);
      tick();
      quiet(); #1;
      chk("occ_rmask0", 32'(bus.mem_rmask), 32'h0);
      chk("occ_dresp0", 32'(bus.dmem_resp), 32'h0);
      tick();
      bus.mem_resp = 1'b1; bus.mem_rdata = 32'h00000055; #1;
      chk("occ_dresp", 32'(bus.dmem_resp), 32'h1);
      chk("occ_ddata", bus.dmem_rdata, 32'h00000055);
      tick();
      quiet();
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("occ_no_reissue", 32'(bus.mem_rmask), 32'h0);
         chk("occ_addr_hold",  bus.mem_addr, 32'h00002000);
         chk("occ_idle",       32'(dut.r_state), 32'(IDLE));
         tick();
      end

      // Reset mid-transaction, then a stale response.
      bus.dmem_addr = 32'h00004000; bus.dmem_wmask = 4'hf; bus.dmem_wdata = 32'h00001234;
      tick();
      quiet(); #1;
      chk("rmid_wmask", 32'(bus.mem_wmask), 32'hf);
      chk("rmid_state", 32'(dut.r_state), 32'(BUSY_D));
      rst = 1'b1;
      tick();
      rst = 1'b0; bus.mem_resp = 1'b1; bus.mem_rdata = 32'hffffffff; #1;
      chk("rmid_dresp", 32'(bus.dmem_resp), 32'h0);
      chk("rmid_iresp", 32'(bus.imem_resp), 32'h0);
      chk("rmid_state2", 32'(dut.r_state), 32'(IDLE));
      chk("rmid_addr",  bus.mem_addr, 32'h0);
      chk("rmid_wdata", bus.mem_wdata, 32'h0);
      chk("rmid_wmask0", 32'(bus.mem_wmask), 32'h0);
      chk("rmid_rmask0", 32'(bus.mem_rmask), 32'h0);
      tick();
      quiet(); #1;
      chk("rmid_after", 32'(dut.r_state), 32'(IDLE));
      tick();

      // Stray response in IDLE.
      bus.mem_resp = 1'b1; bus.mem_rdata = 32'h12345678; #1;
      chk("stray_iresp", 32'(bus.imem_resp), 32'h0);
      chk("stray_dresp", 32'(bus.dmem_resp), 32'h0);
      tick();
      quiet(); #1;
      chk("stray_state", 32'(dut.r_state), 32'(IDLE));
      chk("stray_rmask", 32'(bus.mem_rmask), 32'h0);
      tick();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one external memory port between the pipeline's instruction-fetch requester (imem) and load/store requester (dmem). Each side's request is captured into a one-entry pending slot and issued on the shared port one transaction at a time. The response is routed back to the requester that owns the transaction. The block sits between the `cpu` memory interfaces and the single-ported memory model or cache.

## Interface
Parameters:
- None. Widths are fixed: 32-bit address and data, 4-bit byte masks.

Ports:
- `clk`  in  1  — sole clock; all state updates on the rising edge.
- `rst`  in  1  — reset, synchronous, active-high.
- `imem_addr`  in  32  — fetch address.
- `imem_rmask`  in  4  — fetch request; nonzero means request.
- `imem_rdata`  out  32  — fetch data; valid when `imem_resp`=1.
- `imem_resp`  out  1  — fetch complete.
- `dmem_addr`  in  32  — load/store address.
- `dmem_rmask`  in  4  — load byte mask.
- `dmem_wmask`  in  4  — store byte mask. A request is present when rmask|wmask is nonzero.
- `dmem_wdata`  in  32  — store data.
- `dmem_rdata`  out  32  — load data; valid when `dmem_resp`=1.
- `dmem_resp`  out  1  — load/store complete.
- `mem_addr`  out  32  — shared-port address (registered).
- `mem_rmask`  out  4  — shared-port read mask (registered).
- `mem_wmask`  out  4  — shared-port write mask (registered).
- `mem_wdata`  out  32  — shared-port write data (registered).
- `mem_rdata`  in  32  — shared-port read data.
- `mem_resp`  in  1  — shared-port completion.

## Operation
- Each port has one pending slot holding addr, rmask, wmask and wdata (wmask and wdata are 0 for the imem slot).
- Slot capture: when a port's mask is nonzero and its slot is empty, or the slot is retiring this cycle, the request is written into the slot at the edge.
- A request seen while the slot is occupied and not retiring is ignored (protocol violation; no other effect).
- State machine (`arb_state_t`) has three states: IDLE, BUSY_I, BUSY_D.
  - IDLE → BUSY_D when the dmem slot is valid or a dmem request is arriving. dmem has priority, because it belongs to the older instruction.
  - IDLE → BUSY_I otherwise, when the imem slot is valid or an imem request is arriving.
  - IDLE → IDLE when there is nothing to issue.
  - BUSY_x → (grant decision, as from IDLE) on `mem_resp`=1. The owner's slot retires in that same cycle.
  - BUSY_x → BUSY_x while `mem_resp`=0.
- Issue: on entering BUSY_x, the mem_* registers load the granted slot's contents. `mem_rmask`/`mem_wmask` are nonzero for exactly one cycle, then return to 0. `mem_addr`/`mem_wdata` hold their value until the next issue.
- Response routing is combinational:
  - `imem_resp` = `mem_resp` & (state==BUSY_I).
  - `dmem_resp` = `mem_resp` & (state==BUSY_D).
  - `imem_rdata` = `dmem_rdata` = `mem_rdata`.
- A `mem_resp` received in IDLE is ignored. This includes a stale response arriving after reset.
- Simultaneous requests on both ports: dmem is issued first and imem waits in its slot. Starvation is not possible: a new dmem request needs a new instruction, which needs a fetch.

## Timing
- Reset values: state IDLE, both slots empty, mem_addr/mem_wdata 0, mem_rmask/mem_wmask 0, imem_resp/dmem_resp 0.
- Request present in cycle T, port idle → shared-port mask asserted in T+1 only.
- `mem_resp` in cycle R → owner `*_resp` asserted in R, with rdata from the same cycle.
- A waiting request is issued in R+1, giving zero bubble cycles between transactions.
- A requester may issue its next request in its own response cycle R. It is captured and can be granted for R+1.
- `rst` mid-transaction clears the slots and returns to IDLE at that edge. Outputs take their reset values in the following cycle.

## Structure
- Add to the shared package `rv32i_types`:
  - `arb_state_t` enum {IDLE, BUSY_I, BUSY_D}.
  - `mem_req_t` struct {addr[31:0], rmask[3:0], wmask[3:0], wdata[31:0]}.
- One sub-module, `mem_req_slot`: a single-entry holding register with valid, capture and retire inputs. It is instantiated twice, once for imem and once for dmem.
- Grant decision, FSM and registered mem_* outputs live in `mem_port_arbiter`.

## Test plan
- Single fetch: imem_addr=0x1eceb000, rmask=4'hf in cycle 1 → mem_rmask=4'hf, mem_addr=0x1eceb000 in cycle 2 only. mem_resp with rdata=0x00000013 in cycle 4 → imem_resp=1, imem_rdata=0x00000013 in cycle 4; dmem_resp stays 0.
- Simultaneous requests: imem 0x1eceb004 and dmem store 0x1eceb100 (wmask=4'h3, wdata=0xdead) in the same cycle → store issued first. After its mem_resp, the fetch is issued the very next cycle with mem_wmask=0.
- Back-to-back: a new imem request presented in the imem_resp cycle → issued the next cycle, with no idle cycle on the shared port.
- Occupied slot: a second dmem request while dmem is outstanding → ignored; only one dmem_resp is produced.
- Reset mid-operation: rst during BUSY_D, then a stale mem_resp=1 → no *_resp asserted; state IDLE; all mem_* outputs 0.
- Stray response: mem_resp=1 in IDLE with no traffic → no *_resp asserted, state unchanged.
